fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction buffer directly downstream of the BTB lookup in the fetch stage. Each entry captures one fetched instruction together with its PC and the BTB prediction for that PC: hit flag plus predicted target. Entries are presented in order to decode. A controller redirect (irregular PC) discards every in-flight entry.

Parameters:
DEPTH, 4, number of entries; must be a power of two and at least 2.
ADDR_WIDTH, 32, PC width; matches BasicTypes ADDR_WIDTH.
INSN_WIDTH, 32, instruction word width.

Ports:
clk  in  1  clock, rising edge.
rstN  in  1  asynchronous active-low reset.
enqValid  in  1  fetch offers an entry this cycle.
enqReady  out  1  queue can accept an entry.
enqPc  in  ADDR_WIDTH  PC of the fetched instruction.
enqInsn  in  INSN_WIDTH  fetched instruction word.
enqBtbHit  in  1  BTB hit for enqPc.
enqBtbPredictedPc  in  ADDR_WIDTH  BTB predicted target; meaningful only when enqBtbHit=1.
flush  in  1  controller redirect; irregular PC is non-zero this cycle.
deqValid  out  1  head entry valid.
deqReady  in  1  decode consumes the head this cycle.
deqPc  out  ADDR_WIDTH  head PC.
deqInsn  out  INSN_WIDTH  head instruction.
deqPredTaken  out  1  head was predicted taken (BTB hit).
deqPredPc  out  ADDR_WIDTH  head predicted next PC.
count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer with read/write pointers of width $clog2(DEPTH)+1; the extra MSB is the wrap bit.
  - empty = pointers equal.
  - full = indices equal and wrap bits differ.
- Reset (rstN=0, asynchronous): both pointers 0 and count=0. Outputs are then enqReady=1, deqValid=0, deqPc=0, deqInsn=0, deqPredTaken=0, deqPredPc=0. Entry array contents are not reset.
- enqReady = !full. It is registered-state only and does not depend on deqReady; there is no enqueue-on-full even with a simultaneous dequeue.
- Enqueue: enqValid && enqReady && !flush.
  - Writes {enqPc, enqInsn, enqBtbHit, predPc} at the write index on the rising edge, then the write pointer increments.
  - predPc = enqBtbPredictedPc if enqBtbHit, else enqPc+4 (modulo 2^ADDR_WIDTH).
- Dequeue: deqValid && deqReady && !flush. The read pointer increments on the rising edge.
- deq* outputs are combinational reads of the head entry when deqValid=1, and are driven to 0 when empty.
- Latency: an entry written at edge N is visible at deq during cycle N+1 (one cycle minimum).
- Simultaneous enqueue and dequeue when neither empty nor full: both pointers advance and count is unchanged.
- Enqueue while empty: deqValid=0 that cycle; the entry appears the next cycle.
- Flush has priority over everything.
  - On the edge where flush=1, the read pointer is set equal to the write pointer, so count becomes 0.
  - Any enqueue or dequeue in that cycle is ignored.
  - deqValid still reflects the pre-flush state during the flush cycle; decode must ignore it when flush=1.
- Pointer wrap: indices wrap modulo DEPTH and the wrap bit toggles on each index overflow.
- count = writePtr - readPtr, computed at width $clog2(DEPTH)+1.
- Reset mid-operation: state clears immediately and asynchronously; the first legal enqueue is on the first edge after rstN rises.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined: when the queue is empty, enqValid=1 and flush=0, the incoming entry drives deq* combinationally and deqValid=1 that cycle.
  - If deqReady=1 in that cycle, the entry is consumed and never written; pointers are unchanged.
  - If deqReady=0, the entry is written normally.
- Not defined: no bypass; minimum latency is one cycle, as in Behaviour.

Decomposition:
- FetchUnitTypes package additions:
  - FETCH_QUEUE_DEPTH constant.
  - FetchQueueIndex typedef (index plus wrap bit).
  - FetchQueueEntry packed struct {pc, insn, predTaken, predPc}.
- One sub-module, fetch_queue_ram: DEPTH x $bits(FetchQueueEntry) register array with one synchronous write port and one asynchronous read port. Pointer, flush and bypass control stay in fetch_queue.

Test Plan:
1. Reset then idle: after rstN deasserts, enqReady=1, deqValid=0, count=0, all deq* = 0.
2. Enqueue PC 0x100 (insn 0x00000013, hit=0), then PC 0x104 (hit=1, target 0x200), with deqReady=0 throughout:
   - count=2.
   - Head is deqPc=0x100, deqPredTaken=0, deqPredPc=0x104.
   - After one dequeue: deqPc=0x104, deqPredTaken=1, deqPredPc=0x200.
3. Fill with DEPTH=4 entries:
   - enqReady=0 and count=4.
   - A fifth enqValid with deqReady=1 is not accepted; next cycle count=3 and enqReady=1.
4. Continuous enqueue and dequeue for 10 entries at PCs 0x0-0x24: in-order output, pointers wrap twice, count stays 1 throughout.
5. With 3 entries queued, assert flush together with enqValid and deqReady:
   - Next cycle count=0, deqValid=0, and the flushed-cycle enqueue is absent.
   - A following enqueue of PC 0x300 appears as the head.
6. BYPASS_EN build, queue empty, enqValid=1 at PC 0x400, deqReady=1: deqValid=1 and deqPc=0x400 in the same cycle, count stays 0. Non-bypass build: deqValid=0 that cycle.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and sizing helpers for the fetch-stage instruction queue.
package fetch_queue_pkg;

  localparam int FETCH_QUEUE_DEPTH = 4;
  localparam int FQ_ADDR_WIDTH     = 32;
  localparam int FQ_INSN_WIDTH     = 32;

  // Pointer width: index bits plus one wrap bit.
  function automatic int fq_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [fq_ptr_width(FETCH_QUEUE_DEPTH)-1:0] FetchQueueIndex;

  typedef struct packed {
    logic [FQ_ADDR_WIDTH-1:0] pc;
    logic [FQ_INSN_WIDTH-1:0] insn;
    logic                     predTaken;
    logic [FQ_ADDR_WIDTH-1:0] predPc;
  } FetchQueueEntry;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for fetch_queue: register array, one synchronous write port,
// one asynchronous read port. Contents are intentionally not reset.
module fetch_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 97
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction queue between BTB lookup and decode, flushed on redirect.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH      = FETCH_QUEUE_DEPTH,
  parameter int ADDR_WIDTH = FQ_ADDR_WIDTH,
  parameter int INSN_WIDTH = FQ_INSN_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     enqValid,
  output logic                     enqReady,
  input  logic [ADDR_WIDTH-1:0]    enqPc,
  input  logic [INSN_WIDTH-1:0]    enqInsn,
  input  logic                     enqBtbHit,
  input  logic [ADDR_WIDTH-1:0]    enqBtbPredictedPc,
  input  logic                     flush,
  output logic                     deqValid,
  input  logic                     deqReady,
  output logic [ADDR_WIDTH-1:0]    deqPc,
  output logic [INSN_WIDTH-1:0]    deqInsn,
  output logic                     deqPredTaken,
  output logic [ADDR_WIDTH-1:0]    deqPredPc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = fq_ptr_width(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INSN_WIDTH-1:0] insn;
    logic                  predTaken;
    logic [ADDR_WIDTH-1:0] predPc;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, bypass;
  logic             enq_fire, deq_fire, do_write, do_read;
  entry_t           in_entry, head_entry;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                    (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign enqReady = !full;
  assign count    = wr_ptr - rd_ptr;

  always_comb begin
    in_entry.pc        = enqPc;
    in_entry.insn      = enqInsn;
    in_entry.predTaken = enqBtbHit;
    in_entry.predPc    = enqBtbHit ? enqBtbPredictedPc : enqPc + ADDR_WIDTH'(4);
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && enqValid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign deqValid = !empty || bypass;
  assign enq_fire = enqValid && enqReady && !flush;
  assign deq_fire = deqValid && deqReady && !flush;
  // A bypassed entry that decode takes immediately is never stored.
  assign do_write = enq_fire && !(bypass && deqReady);
  assign do_read  = deq_fire && !bypass;

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr[IDX_W-1:0]),
    .wdata (in_entry),
    .raddr (rd_ptr[IDX_W-1:0]),
    .rdata (head_entry)
  );

  always_comb begin
    deqPc        = '0;
    deqInsn      = '0;
    deqPredTaken = 1'b0;
    deqPredPc    = '0;
    if (bypass) begin
      deqPc        = in_entry.pc;
      deqInsn      = in_entry.insn;
      deqPredTaken = in_entry.predTaken;
      deqPredPc    = in_entry.predPc;
    end else if (!empty) begin
      deqPc        = head_entry.pc;
      deqInsn      = head_entry.insn;
      deqPredTaken = head_entry.predTaken;
      deqPredPc    = head_entry.predPc;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_read)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enqValid, enqReady, enqBtbHit, flush, deqValid, deqReady, deqPredTaken;
  logic [31:0] enqPc, enqInsn, enqBtbPredictedPc, deqPc, deqInsn, deqPredPc;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .INSN_WIDTH(32)) dut (
    .clk               (clk),
    .rstN              (rstN),
    .enqValid          (enqValid),
    .enqReady          (enqReady),
    .enqPc             (enqPc),
    .enqInsn           (enqInsn),
    .enqBtbHit         (enqBtbHit),
    .enqBtbPredictedPc (enqBtbPredictedPc),
    .flush             (flush),
    .deqValid          (deqValid),
    .deqReady          (deqReady),
    .deqPc             (deqPc),
    .deqInsn           (deqInsn),
    .deqPredTaken      (deqPredTaken),
    .deqPredPc         (deqPredPc),
    .count             (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        taken;
    logic [31:0] ppc;
  } ent_t;

  ent_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic seen_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk_in();
    ent_t e;
    e.pc    = enqPc;
    e.insn  = enqInsn;
    e.taken = enqBtbHit;
    e.ppc   = enqBtbHit ? enqBtbPredictedPc : enqPc + 32'd4;
    return e;
  endfunction

  // Compare all outputs against the model's view of the current cycle.
  task automatic check_outputs(input string tag);
    ent_t exp_e;
    logic empty, byp, ev;
    empty = (q.size() == 0);
    byp   = BYP && empty && enqValid && !flush;
    ev    = !empty || byp;
    exp_e = '0;
    if (byp) exp_e = mk_in();
    else if (!empty) exp_e = q[0];
    cmp({tag, ".enqReady"}, 64'(enqReady), 64'(q.size() < DEPTH));
    cmp({tag, ".count"}, 64'(count), 64'(q.size()));
    cmp({tag, ".deqValid"}, 64'(deqValid), 64'(ev));
    cmp({tag, ".deqPc"}, 64'(deqPc), 64'(exp_e.pc));
    cmp({tag, ".deqInsn"}, 64'(deqInsn), 64'(exp_e.insn));
    cmp({tag, ".deqPredTaken"}, 64'(deqPredTaken), 64'(exp_e.taken));
    cmp({tag, ".deqPredPc"}, 64'(deqPredPc), 64'(exp_e.ppc));
  endtask

  task automatic update_model();
    logic empty, byp, ev, take_in, take_out;
    ent_t e;
    e     = mk_in();
    empty = (q.size() == 0);
    byp   = BYP && empty && enqValid && !flush;
    ev    = !empty || byp;
    if (flush) begin
      q.delete();
    end else if (!(byp && deqReady)) begin
      take_in  = enqValid && (q.size() < DEPTH);
      take_out = ev && deqReady && !byp;
      if (take_out) void'(q.pop_front());
      if (take_in) q.push_back(e);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic [31:0] insn, input logic hit, input logic [31:0] tgt,
                      input logic fl, input logic dr);
    @(negedge clk);
    enqValid = v; enqPc = pc; enqInsn = insn; enqBtbHit = hit;
    enqBtbPredictedPc = tgt; flush = fl; deqReady = dr;
    #1;
    check_outputs(tag);
    seen_valid = deqValid;
    @(posedge clk);
    update_model();
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rstN = 1'b0; enqValid = 0; enqPc = 0; enqInsn = 0; enqBtbHit = 0;
    enqBtbPredictedPc = 0; flush = 0; deqReady = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;

    // 1: reset then idle
    #1;
    cmp("rst.enqReady", 64'(enqReady), 64'd1);
    cmp("rst.deqValid", 64'(deqValid), 64'd0);
    cmp("rst.count", 64'(count), 64'd0);
    cmp("rst.deqPc", 64'(deqPc), 64'd0);
    cmp("rst.deqPredPc", 64'(deqPredPc), 64'd0);
    idle("t1");

    // 2: two entries, miss then hit
    step("t2a", 1, 32'h100, 32'h00000013, 0, 32'hdead, 0, 0);
    step("t2b", 1, 32'h104, 32'h00000093, 1, 32'h200, 0, 0);
    #1;
    cmp("t2.count", 64'(count), 64'd2);
    cmp("t2.headPc", 64'(deqPc), 64'h100);
    cmp("t2.headPredPc", 64'(deqPredPc), 64'h104);
    step("t2deq", 0, 32'h0, 32'h0, 0, 32'h0, 0, 1);
    #1;
    cmp("t2.pc2", 64'(deqPc), 64'h104);
    cmp("t2.taken2", 64'(deqPredTaken), 64'd1);
    cmp("t2.ppc2", 64'(deqPredPc), 64'h200);

    // 3: fill, then a refused fifth enqueue alongside a dequeue
    for (int i = 0; i < 3; i++)
      step("t3fill", 1, 32'h500 + 32'(i * 4), 32'(i), 0, 32'h0, 0, 0);
    #1;
    cmp("t3.full.enqReady", 64'(enqReady), 64'd0);
    cmp("t3.full.count", 64'(count), 64'd4);
    step("t3fifth", 1, 32'h600, 32'h6, 0, 32'h0, 0, 1);
    #1;
    cmp("t3.after.count", 64'(count), 64'd3);
    cmp("t3.after.enqReady", 64'(enqReady), 64'd1);
    repeat (3) step("t3drain", 0, 32'h0, 32'h0, 0, 32'h0, 0, 1);

    // 4: streaming through ten PCs, pointers wrap
    step("t4first", 1, 32'h0, 32'h1000, 0, 32'h0, 0, BYP ? 1'b0 : 1'b1);
    for (int i = 1; i < 10; i++) begin
      step("t4stream", 1, 32'(i * 4), 32'h1000 + 32'(i), 0, 32'h0, 0, 1);
      #1;
      cmp("t4.count", 64'(count), 64'd1);
    end
    step("t4last", 0, 32'h0, 32'h0, 0, 32'h0, 0, 1);

    // 5: flush beats simultaneous enqueue and dequeue
    for (int i = 0; i < 3; i++)
      step("t5fill", 1, 32'h700 + 32'(i * 4), 32'(i), 1, 32'h800, 0, 0);
    step("t5flush", 1, 32'h7f0, 32'h7f, 0, 32'h0, 1, 1);
    #1;
    cmp("t5.count", 64'(count), 64'd0);
    cmp("t5.deqValid", 64'(deqValid), 64'd0);
    step("t5enq", 1, 32'h300, 32'h3, 0, 32'h0, 0, 0);
    #1;
    cmp("t5.headPc", 64'(deqPc), 64'h300);
    step("t5drain", 0, 32'h0, 32'h0, 0, 32'h0, 0, 1);

    // 6: enqueue into empty with decode ready
    step("t6", 1, 32'h400, 32'h4, 0, 32'h0, 0, 1);
    cmp("t6.sameCycleValid", 64'(seen_valid), 64'(BYP));
    #1;
    cmp("t6.countAfter", 64'(count), BYP ? 64'd0 : 64'd1);
    step("t6drain", 0, 32'h0, 32'h0, 0, 32'h0, 0, 1);

    // Randomized traffic with an asynchronous reset midway
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        cmp("midrst.count", 64'(count), 64'd0);
        cmp("midrst.deqValid", 64'(deqValid), 64'd0);
        cmp("midrst.enqReady", 64'(enqReady), 64'd1);
        q.delete();
        @(negedge clk) rstN = 1'b1;
      end
      step("rand", 1'($urandom_range(0, 9) < 6), $urandom, $urandom,
           1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
